// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the IF/MEM memory port arbiter and the load/store path.
// Provides the FSM states, requester ids, access-size codes and the alignment check.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Byte accesses are never misaligned; halves need bit 0 clear, words need bits [1:0] clear.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_port_arbiter_lat_counter.sv
// Loadable down-counter that times a fixed-latency memory access.
// last_o is high in the final cycle of the access (count == 1).
module mem_lat_counter #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic last_o
);

    localparam int            CW       = $clog2(LAT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(LAT);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == ONE);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported unified memory between instruction fetch and load/store.
// Each grant occupies IDLE -> BUSY (LAT cycles) -> DONE; misaligned data accesses skip BUSY.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_ready,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_misalign,
    output logic              d_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q,    state_d;
    owner_e            owner_q,    owner_d;
    logic              last_d_q,   last_d_d;
    logic [ADDR_W-1:0] addr_q,     addr_d;
    logic              we_q,       we_d;
    logic [1:0]        size_q,     size_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              kill_q,     kill_d;
    logic              misal_q,    misal_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,  d_rdata_d;

    logic if_elig;
    logic grant_d;
    logic grant_if;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_last;
    logic busy;
    logic done;

    // A fetch being redirected this cycle is not worth starting; D wins unless it won last time.
    assign if_elig  = if_req & ~if_flush;
    assign grant_d  = d_req & (~if_elig | ~last_d_q);
    assign grant_if = if_elig & ~grant_d;

    mem_lat_counter #(
        .LAT (LAT)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .last_o (cnt_last)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d_d   = last_d_q;
        addr_d     = addr_q;
        we_d       = we_q;
        size_d     = size_q;
        wdata_d    = wdata_q;
        kill_d     = kill_q;
        misal_d    = misal_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    owner_d  = OWN_D;
                    addr_d   = d_addr;
                    we_d     = d_we;
                    size_d   = d_size;
                    wdata_d  = d_wdata;
                    last_d_d = if_req;
                    kill_d   = 1'b0;
                    if (is_misaligned(d_size, d_addr[1:0])) begin
                        misal_d   = 1'b1;
                        d_rdata_d = '0;
                        state_d   = DONE;
                    end else begin
                        misal_d  = 1'b0;
                        cnt_load = 1'b1;
                        state_d  = BUSY;
                    end
                end else if (grant_if) begin
                    owner_d  = OWN_IF;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    size_d   = SZ_WORD;
                    wdata_d  = '0;
                    last_d_d = 1'b0;
                    kill_d   = 1'b0;
                    misal_d  = 1'b0;
                    cnt_load = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                cnt_dec = 1'b1;
                // The memory cannot abort, so a redirect only suppresses the eventual ready.
                if ((owner_q == OWN_IF) && if_flush) begin
                    kill_d = 1'b1;
                end
                if (cnt_last) begin
                    if (owner_q == OWN_IF) begin
                        if_rdata_d = mem_rdata;
                    end else if (!we_q) begin
                        d_rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            last_d_q   <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            wdata_q    <= '0;
            kill_q     <= 1'b0;
            misal_q    <= 1'b0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_d_q   <= last_d_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            size_q     <= size_d;
            wdata_q    <= wdata_d;
            kill_q     <= kill_d;
            misal_q    <= misal_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign done = (state_q == DONE);

    // A flush landing in the DONE cycle itself must also swallow the fetch result.
    assign if_ready   = done & (owner_q == OWN_IF) & ~kill_q & ~if_flush;
    assign d_ready    = done & (owner_q == OWN_D);
    assign d_misalign = d_ready & misal_q;
    assign if_stall   = if_req & ~if_ready;
    assign d_stall    = d_req & ~d_ready;
    assign if_rdata   = if_rdata_q;
    assign d_rdata    = d_rdata_q;

    assign mem_en    = busy;
    assign mem_we    = busy & we_q;
    assign mem_size  = busy ? size_q  : 2'b00;
    assign mem_addr  = busy ? addr_q  : '0;
    assign mem_wdata = busy ? wdata_q : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two requester agents, a latency-accurate memory,
// and a transaction-timeline reference model (grant cycle + fixed occupancy).
module tb_mem_port_arbiter;
    import core_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int NCYC = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, if_flush, if_ready, if_stall;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          d_req, d_we, d_ready, d_misalign, d_stall;
    logic [1:0]    d_size;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic          mem_en, mem_we;
    logic [1:0]    mem_size;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .LAT    (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_ready   (if_ready),
        .if_rdata   (if_rdata),
        .if_stall   (if_stall),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .d_misalign (d_misalign),
        .d_stall    (d_stall),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_size   (mem_size),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Memory: content is a fixed hash of the word address, valid only in the LAT-th enable cycle.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ({a[31:2], 2'b00} * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    int en_cnt = 0;
    always @(posedge clk) en_cnt <= mem_en ? en_cnt + 1 : 0;
    assign mem_rdata = (mem_en && !mem_we && en_cnt == LAT - 1) ? mem_word(mem_addr) : 32'hDEAD_BEEF;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: at most one transaction scheduled, identified by its grant cycle.
    bit          act = 0;
    int          g = 0;
    int          free_at = 0;
    bit          m_own_d, m_we, m_misal, m_kill, m_last_d;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    logic [31:0] exp_d_rdata;

    // Requester agents
    bit          ifa_on = 0, da_on = 0, flush_prev = 0;
    bit          prev_if_rdy = 0, prev_d_rdy = 0;
    logic [31:0] ifa_pc = '0;
    logic        da_we;
    logic [1:0]  da_size, lo;
    logic [31:0] da_addr, da_wdata;
    int          n_txn = 0;

    initial begin
        bit busy_e, done_e, e_if_rdy, e_d_rdy, if_el;
        rst = 1'b1; if_req = 0; if_addr = '0; if_flush = 0;
        d_req = 0; d_we = 0; d_size = '0; d_addr = '0; d_wdata = '0;

        @(negedge clk);
        @(negedge clk);
        cyc = 1;
        #1;
        chk("rst_mem_en",   32'(mem_en),     32'd0);
        chk("rst_mem_we",   32'(mem_we),     32'd0);
        chk("rst_mem_size", 32'(mem_size),   32'd0);
        chk("rst_mem_addr", mem_addr,        32'd0);
        chk("rst_mem_wdat", mem_wdata,       32'd0);
        chk("rst_if_rdy",   32'(if_ready),   32'd0);
        chk("rst_d_rdy",    32'(d_ready),    32'd0);
        chk("rst_misal",    32'(d_misalign), 32'd0);
        chk("rst_if_rdata", if_rdata,        32'd0);
        chk("rst_d_rdata",  d_rdata,         32'd0);
        chk("rst_if_stall", 32'(if_stall),   32'd0);
        chk("rst_d_stall",  32'(d_stall),    32'd0);
        m_last_d = 0; exp_d_rdata = '0; free_at = 2;

        for (int c = 2; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;

            // Fetch agent: holds until ready; a flush redirects the PC from the next cycle.
            if (prev_if_rdy) ifa_on = 0;
            if (flush_prev) ifa_pc = ($urandom & 32'h0000_0FFC);
            if (!ifa_on && $urandom_range(0, 99) < 65) begin
                ifa_on = 1;
                ifa_pc = ($urandom & 32'h0000_0FFC);
            end
            if_flush   = ifa_on && ($urandom_range(0, 99) < 8);
            flush_prev = if_flush;

            // Data agent: new random access after each ready, some misaligned.
            if (prev_d_rdy) da_on = 0;
            if (!da_on && $urandom_range(0, 99) < 55) begin
                da_on    = 1;
                da_we    = 1'($urandom_range(0, 1));
                da_size  = 2'($urandom_range(0, 2));
                lo       = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 99) >= 30) begin
                    if (da_size == SZ_HALF) lo[0] = 1'b0;
                    else if (da_size == SZ_WORD) lo = 2'b00;
                end
                da_addr  = ($urandom & 32'h0000_0FFC) | {30'd0, lo};
                da_wdata = $urandom;
            end

            if_req = ifa_on; if_addr = ifa_pc;
            d_req = da_on; d_we = da_we; d_size = da_size; d_addr = da_addr; d_wdata = da_wdata;

            busy_e = act && !m_misal && (c > g) && (c <= g + LAT);
            done_e = act && (c == g + (m_misal ? 1 : LAT + 1));
            rst    = busy_e && ($urandom_range(0, 99) < 3);
            #1;

            e_if_rdy = done_e && !m_own_d && !m_kill && !if_flush;
            e_d_rdy  = done_e && m_own_d;
            chk("mem_en",   32'(mem_en),     32'(busy_e));
            chk("if_ready", 32'(if_ready),   32'(e_if_rdy));
            chk("d_ready",  32'(d_ready),    32'(e_d_rdy));
            chk("d_misal",  32'(d_misalign), 32'(e_d_rdy && m_misal));
            chk("if_stall", 32'(if_stall),   32'(if_req && !e_if_rdy));
            chk("d_stall",  32'(d_stall),    32'(d_req && !e_d_rdy));
            if (busy_e) begin
                chk("mem_addr", mem_addr,        m_addr);
                chk("mem_we",   32'(mem_we),     32'(m_we));
                chk("mem_size", 32'(mem_size),   32'(m_size));
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                if (!m_own_d && if_flush) m_kill = 1;
            end
            if (e_if_rdy) chk("if_rdata", if_rdata, mem_word(m_addr));
            if (e_d_rdy) begin
                if (m_misal) exp_d_rdata = '0;
                else if (!m_we) exp_d_rdata = mem_word(m_addr);
                chk("d_rdata", d_rdata, exp_d_rdata);
            end

            if (done_e) begin
                n_txn++;
                $display("txn %0d cyc %0d %s addr=%h we=%0d size=%0d misal=%0d %s",
                         n_txn, c, m_own_d ? "D " : "IF", m_addr, m_we, m_size, m_misal,
                         (!m_own_d && !e_if_rdy) ? "killed" : "done");
                act = 0;
            end

            if (rst) begin
                $display("reset at cyc %0d during %s access addr=%h", c, m_own_d ? "D" : "IF", m_addr);
                act = 0; m_last_d = 0; exp_d_rdata = '0; free_at = c + 1;
            end else if (!act && c >= free_at) begin
                if_el = if_req && !if_flush;
                if (d_req && (!if_el || !m_last_d)) begin
                    act = 1; m_own_d = 1;
                    m_addr = d_addr; m_we = d_we; m_size = d_size; m_wdata = d_wdata;
                    m_misal = (d_size == SZ_HALF && d_addr[0]) ||
                              (d_size == SZ_WORD && d_addr[1:0] != 2'b00);
                    m_last_d = if_req;
                end else if (if_el) begin
                    act = 1; m_own_d = 0;
                    m_addr = if_addr; m_we = 0; m_size = SZ_WORD; m_wdata = '0;
                    m_misal = 0; m_last_d = 0;
                end
                if (act) begin
                    g = c; m_kill = 0;
                    free_at = c + (m_misal ? 2 : LAT + 2);
                end
            end

            prev_if_rdy = e_if_rdy;
            prev_d_rdy  = e_d_rdy;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (loads and stores) of the 5-stage pipelined core. Each transaction runs through a small FSM and a fixed-latency counter. The block returns registered read data and drives per-requester stall signals into the pipeline stall/flush logic. A taken branch or jump can kill an in-flight fetch.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, data width.
- LAT, 2, memory access latency in cycles (must be >= 1).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high until if_ready.
- if_addr  in  ADDR_W  fetch address (PC).
- if_flush  in  1  taken branch/jump; kills pending fetch.
- if_ready  out  1  one-cycle pulse: fetch complete.
- if_rdata  out  DATA_W  fetched instruction; valid while if_ready.
- if_stall  out  1  if_req & ~if_ready.
- d_req  in  1  data request; held high until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  00 byte, 01 half, 10 word.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  raw load word; valid while d_ready.
- d_misalign  out  1  pulse with d_ready when the access was misaligned.
- d_stall  out  1  d_req & ~d_ready.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_size  out  2  access size to memory.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid LAT cycles after the first mem_en cycle.

Behaviour:
- States:
  - IDLE, BUSY, DONE.
  - owner register: IF or D.
  - last_d register: set when the previous grant was to D while if_req was high.
- Reset: state = IDLE, owner = IF, last_d = 0, counter = 0. All outputs are 0: if_rdata, d_rdata, mem_* and the ready pulses. The stall outputs follow their equations.
- Reset mid-transaction: the FSM returns to IDLE at the next edge. mem_en is low from the following cycle. No ready pulse is produced.
- IDLE, arbitration on sampled requests:
  - d_req only: grant D.
  - if_req & ~if_flush only: grant IF.
  - Both pending: grant D unless last_d = 1, in which case grant IF. This alternation prevents fetch starvation.
  - if_req together with if_flush in IDLE: IF is not granted that cycle.
- On grant: latch owner, address, we, size and wdata into registers; load counter = LAT; go to BUSY.
  - IF grant forces we = 0 and size = 10.
- D misalignment: half access with addr[0] = 1, or word access with addr[1:0] != 0.
  - Misaligned D grants go straight to DONE.
  - No mem_en is issued, d_misalign = 1, d_rdata = 0.
- BUSY:
  - mem_en = 1 and mem_* are driven from the latched registers, stable for all LAT cycles.
  - The counter decrements each cycle.
  - When counter = 1: capture mem_rdata into the read register and go to DONE.
- DONE, lasting one cycle:
  - Pulse the ready of the owner; rdata is valid in the same cycle.
  - Stores: ready pulses; d_rdata holds its previous value.
  - Next state is IDLE.
- Latency: a request sampled at edge t gives BUSY in cycles t+1..t+LAT and ready in cycle t+LAT+1. Total occupancy is LAT+2 cycles.
- Requester handshake: the requester drops or changes req/addr at the edge that samples ready high. The arbiter cannot re-grant the same request because it is in DONE.
- if_flush while owner = IF in BUSY:
  - The memory access runs to completion; it cannot be aborted.
  - A kill flag is set, and DONE suppresses if_ready.
  - A flush arriving in the DONE cycle itself also suppresses if_ready.
- if_flush has no effect on D transactions.
- Stalls: if_stall and d_stall are combinational from req and ready, per the port equations.
- Counter width: $clog2(LAT+1). LAT = 1 is legal, with one BUSY cycle.

Decomposition:
- Shared package (core_pkg), holding:
  - state enum {IDLE, BUSY, DONE};
  - owner enum {OWN_IF, OWN_D};
  - size constants SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10.
  - These same size codes are used by the load/store path.
- One natural sub-module: mem_lat_counter. It provides a loadable down-counter with a "last" flag, parameterised by LAT.

Test Plan:
1. LAT=2, if_req=1 with if_addr=0x10 at t=0 → mem_en=1 in cycles 1–2 with mem_addr=0x10; if_ready=1 in cycle 3 with if_rdata=mem word at 0x10; if_stall=1 in cycles 0–2.
2. if_req and d_req both high at t=0, d_addr=0x40 (load word), last_d=0 → D is served first (d_ready at cycle 3), then IF is granted at cycle 4 (if_ready at cycle 7). Repeated contention → grants alternate D, IF, D, IF.
3. Store with d_we=1, d_size=SZ_BYTE, d_addr=0x43, d_wdata=0xAB → mem_we=1, mem_size=00, mem_addr=0x43 for 2 cycles; d_ready pulses; d_rdata unchanged.
4. Fetch 0x20 in BUSY with if_flush=1 at cycle 2 → memory access completes; no if_ready pulse; FSM returns to IDLE at cycle 4; a new fetch of 0x80 completes normally.
5. Load word at d_addr=0x42 → no mem_en; d_ready=1 and d_misalign=1 one cycle after grant; d_rdata=0.
6. rst=1 for one cycle during BUSY → next cycle is IDLE, mem_en=0, no ready pulse; the held d_req is re-granted after rst drops.
